regfile_wb_arbiter: RTL and testbench

- Shares the register file's single write port among NUM_REQ writeback sources (index 0 = ALU, 1 = load unit, 2 = multiplier).
- Uses round-robin arbitration and drives the register file's writeReg/writeData/regWrite inputs from registers.
- Keeps a busy scoreboard of destination registers with writes in flight, and flags read-after-write hazards for the two source operands of the instruction being issued.

---
 rtl/regfile_wb_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register file's single write port among writeback sources.
// It also keeps a busy scoreboard of pending destinations and flags RAW hazards for the issuing instruction.
module regfile_wb_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_rd,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            issue_valid,
    input  logic [ADDR_WIDTH-1:0]           issue_rd,
    input  logic [ADDR_WIDTH-1:0]           issue_rs1,
    input  logic [ADDR_WIDTH-1:0]           issue_rs2,
    output logic                            hazard,
    output logic [(2**ADDR_WIDTH)-1:0]      busy,
    output logic [ADDR_WIDTH-1:0]           writeReg,
    output logic [DATA_WIDTH-1:0]           writeData,
    output logic                            regWrite
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]            rrPtr;
    logic [PTR_W-1:0]            scanIdx;
    logic [PTR_W-1:0]            grantIdx;
    logic                        found;
    logic [NUM_REQ-1:0]          grant;
    logic                        transfer;
    logic [ADDR_WIDTH-1:0]       selRd;
    logic [DATA_WIDTH-1:0]       selData;
    logic [(2**ADDR_WIDTH)-1:0]  busyReg;
    logic [(2**ADDR_WIDTH)-1:0]  busyNext;

    // Scan from rrPtr upward with wraparound; the first valid requester wins.
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        scanIdx  = '0;
        found    = 1'b0;
        if (!reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scanIdx = PTR_W'((int'(rrPtr) + k) % NUM_REQ);
                if (!found && req_valid[scanIdx]) begin
                    found           = 1'b1;
                    grant[scanIdx]  = 1'b1;
                    grantIdx        = scanIdx;
                end
            end
        end
    end

    assign req_ready = grant;
    assign transfer  = found;

    always_comb begin
        selRd   = '0;
        selData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                selRd   = req_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
                selData = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
            rrPtr     <= '0;
        end else if (transfer) begin
            rrPtr     <= (grantIdx == PTR_W'(NUM_REQ - 1)) ? '0 : grantIdx + PTR_W'(1);
            writeReg  <= selRd;
            writeData <= selData;
            regWrite  <= (selRd != '0);
        end else begin
            regWrite  <= 1'b0;
        end
    end

    // Clear first so a same-edge issue to the same register keeps it busy.
    always_comb begin
        busyNext = busyReg;
        if (transfer && selRd != '0)
            busyNext[selRd] = 1'b0;
        if (issue_valid && issue_rd != '0)
            busyNext[issue_rd] = 1'b1;
        busyNext[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset)
            busyReg <= '0;
        else
            busyReg <= busyNext;
    end

    assign busy   = busyReg;
    assign hazard = busyReg[issue_rs1] | busyReg[issue_rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: writes are queued as expected results when granted
// and popped when they reach the register-file port one cycle later.
module tb_regfile_wb_arbiter;

    logic         clock;
    logic         reset;
    logic [2:0]   req_valid;
    logic [14:0]  req_rd;
    logic [95:0]  req_data;
    logic [2:0]   req_ready;
    logic         issue_valid;
    logic [4:0]   issue_rd;
    logic [4:0]   issue_rs1;
    logic [4:0]   issue_rs2;
    logic         hazard;
    logic [31:0]  busy;
    logic [4:0]   writeReg;
    logic [31:0]  writeData;
    logic         regWrite;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
    } wb_t;

    wb_t expQ[$];
    int  checks = 0;
    int  errors = 0;

    regfile_wb_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .hazard      (hazard),
        .busy        (busy),
        .writeReg    (writeReg),
        .writeData   (writeData),
        .regWrite    (regWrite)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setReq(input int i, input logic [4:0] rd, input logic [31:0] data);
        req_rd[i*5 +: 5]     = rd;
        req_data[i*32 +: 32] = data;
    endtask

    // Record the write the bench expects from requester i being granted this cycle.
    task automatic expectGrant(input int i);
        wb_t e;
        e.rd   = req_rd[i*5 +: 5];
        e.data = req_data[i*32 +: 32];
        e.we   = (e.rd != 5'd0);
        expQ.push_back(e);
    endtask

    // Advance one clock and check the register-file port against the scoreboard.
    task automatic tick();
        wb_t e;
        @(posedge clock);
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk("wb_regWrite", regWrite, e.we);
            chk("wb_writeReg", writeReg, e.rd);
            chk("wb_writeData", writeData, e.data);
        end else begin
            chk("idle_regWrite", regWrite, 1'b0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 3'b111;
        req_rd      = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        issue_rs1   = '0;
        issue_rs2   = '0;
        setReq(0, 5'd1, 32'hA000_0001);
        setReq(1, 5'd2, 32'hB000_0002);
        setReq(2, 5'd3, 32'hC000_0003);
        #1;
        chk("reset_ready_pre", req_ready, 3'b000);

        // Reset held for two cycles with every requester valid.
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("reset_ready", req_ready, 3'b000);
            chk("reset_busy", busy, 32'd0);
            chk("reset_writeReg", writeReg, 5'd0);
            chk("reset_writeData", writeData, 32'd0);
        end

        // Round robin with all three valid for six cycles.
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("rr_ready", req_ready, 3'b001 << (c % 3));
            expectGrant(c % 3);
            tick();
        end

        req_valid = 3'b000;
        #1;
        chk("idle_ready", req_ready, 3'b000);
        tick();

        // Single write from the ALU.
        setReq(0, 5'd5, 32'hDEAD_BEEF);
        req_valid = 3'b001;
        #1;
        chk("single_ready", req_ready, 3'b001);
        expectGrant(0);
        tick();
        req_valid = 3'b000;
        #1;
        tick();

        // Write to x0 is granted but dropped.
        setReq(1, 5'd0, 32'h0000_1234);
        req_valid = 3'b010;
        #1;
        chk("x0_ready", req_ready, 3'b010);
        expectGrant(1);
        tick();
        chk("x0_busy", busy, 32'd0);

        // Scoreboard set and hazard detection.
        req_valid   = 3'b000;
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        chk("sb_hazard_before", hazard, 1'b0);
        tick();
        chk("sb_busy7_set", busy, 32'h0000_0080);
        issue_valid = 1'b0;
        issue_rs1   = 5'd7;
        issue_rs2   = 5'd0;
        #1;
        chk("sb_hazard_rs1", hazard, 1'b1);
        issue_rs1 = 5'd4;
        issue_rs2 = 5'd7;
        #1;
        chk("sb_hazard_rs2", hazard, 1'b1);
        issue_rs2 = 5'd9;
        #1;
        chk("sb_hazard_none", hazard, 1'b0);

        // Same-edge clear and set of r7: set wins.
        setReq(2, 5'd7, 32'h0000_0077);
        req_valid   = 3'b100;
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        chk("sb_same_ready", req_ready, 3'b100);
        expectGrant(2);
        tick();
        chk("sb_busy7_kept", busy, 32'h0000_0080);

        // Later write to r7 with no issue clears it.
        issue_valid = 1'b0;
        issue_rs1   = 5'd7;
        setReq(0, 5'd7, 32'h0000_0700);
        req_valid = 3'b001;
        #1;
        chk("sb_clear_ready", req_ready, 3'b001);
        expectGrant(0);
        tick();
        chk("sb_busy7_clear", busy, 32'd0);
        chk("sb_hazard_clear", hazard, 1'b0);

        // Mark r3 busy, then reset while a grant is pending.
        req_valid   = 3'b000;
        issue_valid = 1'b1;
        issue_rd    = 5'd3;
        tick();
        chk("mid_busy3", busy, 32'h0000_0008);
        issue_valid = 1'b0;
        setReq(0, 5'd10, 32'h1111_0010);
        setReq(1, 5'd11, 32'h2222_0011);
        setReq(2, 5'd12, 32'h3333_0012);
        req_valid = 3'b111;
        #1;
        chk("mid_ready_pre", req_ready, 3'b010);
        reset     = 1'b1;
        issue_rs1 = 5'd3;
        #1;
        chk("mid_ready_reset", req_ready, 3'b000);
        chk("mid_hazard_reset", hazard, 1'b1);
        tick();
        chk("mid_busy_reset", busy, 32'd0);
        chk("mid_writeReg_reset", writeReg, 5'd0);
        reset = 1'b0;
        #1;
        chk("mid_ready_restart", req_ready, 3'b001);
        expectGrant(0);
        tick();
        req_valid = 3'b000;
        #1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
